// File: rtl/hsi_com_pkg.sv
// Shared types and helpers for the N-channel HSI command-source selector.
package hsi_com_pkg;

  localparam int SWITCH_CNT_W = 8;
  localparam int MAX_CH       = 8;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    BASE     = 2'd0,
    FAILOVER = 2'd1,
    DEAD     = 2'd2
  } com_state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } ch_sel_t;

  // First usable line scanning cur+1, cur+2, ... modulo n, never returning cur itself.
  function automatic ch_sel_t next_usable(input logic [IDX_W-1:0] cur,
                                          input logic [MAX_CH-1:0] usable,
                                          input int                n);
    ch_sel_t r;
    int      j;
    r = '0;
    // Walk downwards so the closest candidate is the one left in r.
    for (int k = MAX_CH - 1; k >= 1; k--) begin
      if (k < n) begin
        j = (int'(cur) + k) % n;
        if (usable[j]) begin
          r.vld = 1'b1;
          r.idx = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

  // First usable line scanning from start itself, then onwards round-robin.
  function automatic ch_sel_t first_usable(input logic [IDX_W-1:0] start,
                                           input logic [MAX_CH-1:0] usable,
                                           input int                n);
    ch_sel_t r;
    if ((int'(start) < n) && usable[start]) begin
      r.vld = 1'b1;
      r.idx = start;
    end else begin
      r = next_usable(start, usable, n);
    end
    return r;
  endfunction

endpackage

// File: rtl/hsi_com_src_sel_fail_cnt.sv
// Per-line consecutive-failure counter; retires the line once MAX_FAILS is reached.
module hsi_com_fail_cnt #(
  parameter int FAIL_W    = 3,
  parameter int MAX_FAILS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic clr_dead,
  output logic last,
  output logic dead
);

  logic [FAIL_W-1:0] cnt;

  // One more failure on this line would retire it.
  assign last = (cnt >= FAIL_W'(MAX_FAILS - 1));

  // Saturating failure count; dead is sticky until clr_dead or rst.
  always_ff @(posedge clk) begin
    if (rst || clr_dead) begin
      cnt  <= '0;
      dead <= 1'b0;
    end else if (inc) begin
      if (cnt < FAIL_W'(MAX_FAILS)) cnt <= cnt + 1'b1;
      if (last) dead <= 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/hsi_com_src_sel.sv
// Routes the encoder stream onto one of N_CH idle-high command lines with
// round-robin failover, per-line failure retirement and optional revert.
module hsi_com_src_sel
  import hsi_com_pkg::*;
#(
  parameter  int N_CH      = 2,
  parameter  int MAX_FAILS = 4,
  parameter  int FAIL_W    = 3,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_W-1:0]         base_ch,
  input  logic                    sticky_mode,
  input  logic [N_CH-1:0]         ch_en_mask,
  input  logic                    switch_req,
  input  logic                    frame_ok,
  input  logic                    frame_to_reply_end,
  input  logic                    clr_dead,
  input  logic                    cd_q,
  output logic [N_CH-1:0]         com,
  output logic [CH_W-1:0]         active_ch,
  output logic                    switched,
  output logic [N_CH-1:0]         dead_mask,
  output logic                    all_dead,
  output logic [SWITCH_CNT_W-1:0] switch_cnt
);

  com_state_e      state;
  logic [CH_W-1:0] base_lat;
  logic [N_CH-1:0] dead_v;
  logic [N_CH-1:0] last_v;
  logic [N_CH-1:0] inc_v;
  logic [N_CH-1:0] clr_v;
  logic [N_CH-1:0] usable;
  logic [N_CH-1:0] usable_after;
  logic            sw_ev;
  ch_sel_t         nu_sw;
  ch_sel_t         fu_base;
  ch_sel_t         fu_clr;

  function automatic logic [SWITCH_CNT_W-1:0] sat_inc(input logic [SWITCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_fail
    assign inc_v[i] = switch_req && !clr_dead && (state != DEAD) && (active_ch == CH_W'(i));
    assign clr_v[i] = frame_ok && !switch_req && !clr_dead && (active_ch == CH_W'(i));

    hsi_com_fail_cnt #(
      .FAIL_W   (FAIL_W),
      .MAX_FAILS(MAX_FAILS)
    ) u_fail_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_v[i]),
      .clr     (clr_v[i]),
      .clr_dead(clr_dead),
      .last    (last_v[i]),
      .dead    (dead_v[i])
    );
  end

  // Candidate lines for failover, revert and dead-clear, seen with this cycle's retirement.
  always_comb begin
    usable       = ch_en_mask & ~dead_v;
    usable_after = usable;
    if (switch_req && last_v[active_ch]) usable_after[active_ch] = 1'b0;
    // A disabled active line behaves like a switch request without a failure.
    sw_ev   = (state != DEAD) && (switch_req || !ch_en_mask[active_ch]);
    nu_sw   = next_usable(IDX_W'(active_ch), MAX_CH'(usable_after), N_CH);
    fu_base = first_usable(IDX_W'(base_ch), MAX_CH'(usable), N_CH);
    fu_clr  = first_usable(IDX_W'(base_ch), MAX_CH'(ch_en_mask), N_CH);
  end

  // Line selection state: rst > clr_dead > switch > revert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BASE;
      active_ch  <= base_ch;
      base_lat   <= base_ch;
      switch_cnt <= '0;
    end else if (clr_dead) begin
      base_lat <= base_ch;
      if (fu_clr.vld) begin
        active_ch <= CH_W'(fu_clr.idx);
        state     <= (CH_W'(fu_clr.idx) == base_ch) ? BASE : FAILOVER;
      end else begin
        active_ch <= base_ch;
        state     <= DEAD;
      end
    end else if (sw_ev) begin
      if (nu_sw.vld) begin
        active_ch  <= CH_W'(nu_sw.idx);
        switch_cnt <= sat_inc(switch_cnt);
        state      <= (CH_W'(nu_sw.idx) == base_lat) ? BASE : FAILOVER;
      end else if (!usable_after[active_ch]) begin
        state <= DEAD;
      end
    end else if ((state == FAILOVER) && frame_to_reply_end && !sticky_mode) begin
      base_lat <= base_ch;
      if (fu_base.vld) begin
        active_ch <= CH_W'(fu_base.idx);
        state     <= (CH_W'(fu_base.idx) == base_ch) ? BASE : FAILOVER;
      end
    end
  end

  // Only the selected line carries cd_q; everything else idles high.
  always_comb begin
    com = '1;
    if (state != DEAD) com[active_ch] = cd_q;
  end

  assign switched  = (state == FAILOVER);
  assign all_dead  = (state == DEAD);
  assign dead_mask = dead_v;

endmodule

// File: tb/tb_hsi_com_src_sel.sv
// Bench for hsi_com_src_sel: directed vectors, an abstract reference model
// compared every cycle, and literal expectations at key points.
module tb_hsi_com_src_sel;

  localparam int N  = 4;
  localparam int MF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] base_ch;
  logic       sticky_mode;
  logic [3:0] ch_en_mask;
  logic       switch_req;
  logic       frame_ok;
  logic       frame_to_reply_end;
  logic       clr_dead;
  logic       cd_q;
  logic [3:0] com;
  logic [1:0] active_ch;
  logic       switched;
  logic [3:0] dead_mask;
  logic       all_dead;
  logic [7:0] switch_cnt;

  int checks   = 0;
  int failures = 0;

  hsi_com_src_sel #(
    .N_CH     (N),
    .MAX_FAILS(MF),
    .FAIL_W   (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .base_ch           (base_ch),
    .sticky_mode       (sticky_mode),
    .ch_en_mask        (ch_en_mask),
    .switch_req        (switch_req),
    .frame_ok          (frame_ok),
    .frame_to_reply_end(frame_to_reply_end),
    .clr_dead          (clr_dead),
    .cd_q              (cd_q),
    .com               (com),
    .active_ch         (active_ch),
    .switched          (switched),
    .dead_mask         (dead_mask),
    .all_dead          (all_dead),
    .switch_cnt        (switch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_act, m_base, m_cnt, m_st;   // m_st: 0 base line, 1 away from base, 2 no line
  int m_fail[N];
  bit m_dead[N];
  bit m_valid = 1'b0;

  function automatic bit m_usable(int i);
    return ch_en_mask[i] && !m_dead[i];
  endfunction

  function automatic int m_next(int c);
    for (int k = 1; k < N; k++)
      if (m_usable((c + k) % N)) return (c + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_valid = 1'b1;
      m_base  = int'(base_ch);
      m_act   = m_base;
      m_st    = 0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) begin m_fail[i] = 0; m_dead[i] = 1'b0; end
    end else if (m_valid) begin
      if (clr_dead) begin
        for (int i = 0; i < N; i++) begin m_fail[i] = 0; m_dead[i] = 1'b0; end
        m_base = int'(base_ch);
        n = m_usable(m_base) ? m_base : m_next(m_base);
        if (n < 0) begin m_act = m_base; m_st = 2; end
        else begin m_act = n; m_st = (n == m_base) ? 0 : 1; end
      end else begin
        if (frame_ok && !switch_req) m_fail[m_act] = 0;
        if (m_st != 2 && (switch_req || !ch_en_mask[m_act])) begin
          if (switch_req) begin
            if (m_fail[m_act] < MF) m_fail[m_act]++;
            if (m_fail[m_act] >= MF) m_dead[m_act] = 1'b1;
          end
          n = m_next(m_act);
          if (n >= 0) begin
            m_act = n;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_st  = (n == m_base) ? 0 : 1;
          end else if (!m_usable(m_act)) begin
            m_st = 2;
          end
        end else if (m_st == 1 && frame_to_reply_end && !sticky_mode) begin
          m_base = int'(base_ch);
          n = m_usable(m_base) ? m_base : m_next(m_base);
          if (n >= 0) begin m_act = n; m_st = (n == m_base) ? 0 : 1; end
        end
      end
    end
  end

  // Every-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    int ecom, edm;
    if (m_valid) begin
      ecom = 0; edm = 0;
      for (int i = 0; i < N; i++) begin
        ecom |= ((m_st != 2 && i == m_act) ? int'(cd_q) : 1) << i;
        edm  |= int'(m_dead[i]) << i;
      end
      chk("model_com",        int'(com),        ecom);
      if (m_st != 2) chk("model_active_ch", int'(active_ch), m_act);
      chk("model_switched",   int'(switched),   int'(m_st == 1));
      chk("model_all_dead",   int'(all_dead),   int'(m_st == 2));
      chk("model_dead_mask",  int'(dead_mask),  edm);
      chk("model_switch_cnt", int'(switch_cnt), m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [1:0] b);
    base_ch = b; rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic pulse_sw();
    switch_req = 1'b1; cyc(); switch_req = 1'b0;
  endtask

  task automatic pulse_end();
    frame_to_reply_end = 1'b1; cyc(); frame_to_reply_end = 1'b0;
  endtask

  task automatic pulse_ok();
    frame_ok = 1'b1; cyc(); frame_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; base_ch = 2'd1; sticky_mode = 1'b0; ch_en_mask = 4'b1111;
    switch_req = 1'b0; frame_ok = 1'b0; frame_to_reply_end = 1'b0;
    clr_dead = 1'b0; cd_q = 1'b0;
    repeat (2) cyc();

    // Reset state and basic failover / revert
    do_reset(2'd1);
    chk("rst_active", int'(active_ch), 1);
    chk("rst_com", int'(com), 4'b1101);
    chk("rst_switched", int'(switched), 0);
    chk("rst_cnt", int'(switch_cnt), 0);
    pulse_sw();
    chk("t1_active", int'(active_ch), 2);
    chk("t1_com", int'(com), 4'b1011);
    chk("t1_switched", int'(switched), 1);
    cd_q = 1'b1; cyc();
    chk("t1_com_cd1", int'(com), 4'b1111);
    cd_q = 1'b0;
    pulse_end();
    chk("t1_revert", int'(active_ch), 1);
    chk("t1_revert_sw", int'(switched), 0);

    // Sticky mode
    do_reset(2'd1); sticky_mode = 1'b1;
    pulse_sw(); pulse_sw();
    chk("t2_active", int'(active_ch), 3);
    chk("t2_cnt", int'(switch_cnt), 2);
    pulse_end();
    chk("t2_sticky", int'(active_ch), 3);
    chk("t2_switched", int'(switched), 1);
    sticky_mode = 1'b0;

    // Retirement down to no usable line, then recovery
    ch_en_mask = 4'b0110; do_reset(2'd1);
    repeat (4) pulse_sw();
    chk("t3_dead_mask", int'(dead_mask), 4'b0110);
    chk("t3_all_dead", int'(all_dead), 1);
    chk("t3_com", int'(com), 4'b1111);
    chk("t3_cnt", int'(switch_cnt), 3);
    pulse_sw();
    chk("t3_dead_stays", int'(all_dead), 1);
    clr_dead = 1'b1; cyc(); clr_dead = 1'b0;
    chk("t3_clr_active", int'(active_ch), 1);
    chk("t3_clr_mask", int'(dead_mask), 0);
    chk("t3_clr_all_dead", int'(all_dead), 0);
    ch_en_mask = 4'b1111;

    // Switch beats revert in the same cycle
    do_reset(2'd0);
    switch_req = 1'b1; frame_to_reply_end = 1'b1; cyc();
    switch_req = 1'b0; frame_to_reply_end = 1'b0;
    chk("t4_active", int'(active_ch), 1);
    chk("t4_switched", int'(switched), 1);

    // frame_ok clears the consecutive-failure count
    do_reset(2'd1);
    pulse_sw(); pulse_end(); pulse_ok(); pulse_sw();
    chk("t5_active", int'(active_ch), 2);
    chk("t5_dead_mask", int'(dead_mask), 0);

    // Reset in the middle of a failover, new base
    do_reset(2'd3);
    chk("t6_active", int'(active_ch), 3);
    chk("t6_cnt", int'(switch_cnt), 0);
    chk("t6_com", int'(com), 4'b0111);

    // Disabling the active line forces a switch without retiring it
    do_reset(2'd0);
    ch_en_mask = 4'b1110; cyc();
    chk("t7_active", int'(active_ch), 1);
    chk("t7_cnt", int'(switch_cnt), 1);
    chk("t7_dead_mask", int'(dead_mask), 0);
    ch_en_mask = 4'b0000; cyc();
    chk("t7_all_dead", int'(all_dead), 1);
    ch_en_mask = 4'b1111; base_ch = 2'd2;
    clr_dead = 1'b1; cyc(); clr_dead = 1'b0;
    chk("t7_clr_active", int'(active_ch), 2);
    chk("t7_clr_switched", int'(switched), 0);

    // switch_cnt saturation
    do_reset(2'd0); sticky_mode = 1'b1;
    for (int i = 0; i < 260; i++) begin
      pulse_sw(); pulse_ok();
    end
    chk("t8_cnt_sat", int'(switch_cnt), 255);
    chk("t8_dead_mask", int'(dead_mask), 0);
    sticky_mode = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
